// File: rtl/mannix_mem_pkg.sv
// rtl/mannix_mem_pkg.sv - shared definitions for the accelerator memory read server
// Purpose: common line size default, arbiter mode constants and the read-server FSM state type.
// Ports: none (package).
package mannix_mem_pkg;

   localparam int LINE_BYTES_DEF = 32;

   localparam int ARB_RR    = 0;
   localparam int ARB_FIXED = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin / fixed-priority request arbiter
// Purpose: picks one requester per cycle; in round-robin mode it holds the rotating pointer.
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   req         per-requester request vector
//   advance     a grant is being consumed this cycle; moves the pointer past the winner
//   gnt_onehot  one-hot winner (all zero when no request)
//   gnt_idx     binary index of the winner
module rr_arbiter
   import mannix_mem_pkg::*;
#(
   parameter  int N     = 3,
   parameter  int MODE  = ARB_RR,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             advance,
   output logic [N-1:0]     gnt_onehot,
   output logic [IDX_W-1:0] gnt_idx
);

   // ptr is the index that currently has the highest priority
   logic [IDX_W-1:0] ptr;
   logic             found;
   int               cand;

   always_comb begin
      gnt_onehot = '0;
      gnt_idx    = '0;
      found      = 1'b0;
      cand       = 0;
      for (int i = 0; i < N; i++) begin
         if (MODE == ARB_FIXED) begin
            cand = i;
         end else begin
            cand = (int'(ptr) + i) % N;
         end
         if (!found && req[cand]) begin
            found            = 1'b1;
            gnt_onehot[cand] = 1'b1;
            gnt_idx          = IDX_W'(cand);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (advance && found) begin
         ptr <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
   end

endmodule

// File: rtl/mem_rd_arb.sv
// rtl/mem_rd_arb.sv - multi-channel burst read server onto one line-wide SRAM port
// Purpose: arbitrates NUM_CH byte-addressed burst requests, issues one SRAM line read per
//   cycle for the granted burst and returns the lines with valid/last/last_valid.
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   ch_req         per-channel request, held until that channel's last beat
//   ch_start_addr  per-channel byte start address (line offset bits ignored)
//   ch_size_bytes  per-channel burst length in bytes
//   ch_valid       one-hot beat strobe
//   ch_last        one-hot final-beat strobe
//   ch_last_valid  index of the last valid byte of the current beat
//   ch_data        beat data, broadcast, qualified by ch_valid
//   ch_err         one-cycle pulse for a size 0 / oversize request
//   sram_rd_en     SRAM read strobe
//   sram_addr      SRAM line address
//   sram_rdata     SRAM read data, RD_LAT cycles after sram_rd_en
//   busy           high whenever the FSM is not IDLE
module mem_rd_arb
   import mannix_mem_pkg::*;
#(
   parameter  int NUM_CH     = 3,
   parameter  int ADDR_WIDTH = 19,
   parameter  int LINE_BYTES = LINE_BYTES_DEF,
   parameter  int MAX_BYTES  = 512,
   parameter  int RD_LAT     = 1,
   parameter  int ARB_MODE   = ARB_RR,
   localparam int SIZE_W     = $clog2(MAX_BYTES + 1),
   localparam int OFF_W      = $clog2(LINE_BYTES),
   localparam int LADDR_W    = ADDR_WIDTH - OFF_W,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CH-1:0]            ch_req,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_start_addr,
   input  logic [NUM_CH*SIZE_W-1:0]     ch_size_bytes,
   output logic [NUM_CH-1:0]            ch_valid,
   output logic [NUM_CH-1:0]            ch_last,
   output logic [OFF_W-1:0]             ch_last_valid,
   output logic [LINE_BYTES*8-1:0]      ch_data,
   output logic [NUM_CH-1:0]            ch_err,
   output logic                         sram_rd_en,
   output logic [LADDR_W-1:0]           sram_addr,
   input  logic [LINE_BYTES*8-1:0]      sram_rdata,
   output logic                         busy
);

   arb_state_t          state;
   logic [NUM_CH-1:0]   gnt_onehot;
   logic [CH_W-1:0]     gnt_idx;
   logic                advance;

   logic [SIZE_W-1:0]   sel_size;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic                sel_bad;
   logic [SIZE_W:0]     sel_lines;
   logic                unused_addr_lsb;

   logic [CH_W-1:0]     cur_ch;
   logic [LADDR_W-1:0]  line_addr;
   logic [SIZE_W:0]     lines_left;
   logic [OFF_W-1:0]    tail_lv;
   logic [NUM_CH-1:0]   err_q;
   logic                rd_fire;
   logic                issue_last;

   // return pipeline: one entry per cycle of SRAM latency
   logic [RD_LAT-1:0]   pv;
   logic [RD_LAT-1:0]   pl;
   logic [CH_W-1:0]     pc  [RD_LAT];
   logic [OFF_W-1:0]    plv [RD_LAT];

   // the arbiter only consumes a grant in IDLE; errored grants advance it too
   assign advance = (state == IDLE) && (|ch_req);

   rr_arbiter #(
      .N    (NUM_CH),
      .MODE (ARB_MODE)
   ) u_arb (
      .clk        (clk),
      .rst        (rst),
      .req        (ch_req),
      .advance    (advance),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx)
   );

   always_comb begin
      sel_size = '0;
      sel_addr = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (gnt_onehot[i]) begin
            sel_size = ch_size_bytes[i*SIZE_W +: SIZE_W];
            sel_addr = ch_start_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
   end

   assign unused_addr_lsb = ^sel_addr[OFF_W-1:0];
   assign sel_bad   = (sel_size == '0) || (sel_size > SIZE_W'(MAX_BYTES));
   assign sel_lines = ({1'b0, sel_size} + (SIZE_W+1)'(LINE_BYTES - 1)) >> OFF_W;

   assign rd_fire    = (state == ISSUE);
   assign issue_last = (lines_left == (SIZE_W+1)'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cur_ch     <= '0;
         line_addr  <= '0;
         lines_left <= '0;
         tail_lv    <= '0;
         err_q      <= '0;
      end else begin
         err_q <= '0;
         case (state)
            IDLE: begin
               if (advance) begin
                  if (sel_bad) begin
                     err_q <= gnt_onehot;
                  end else begin
                     cur_ch     <= gnt_idx;
                     line_addr  <= sel_addr[ADDR_WIDTH-1:OFF_W];
                     lines_left <= sel_lines;
                     // (size-1) mod LINE_BYTES only needs the low offset bits
                     tail_lv    <= sel_size[OFF_W-1:0] - OFF_W'(1);
                     state      <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               // line address wraps naturally at the top of the SRAM
               line_addr  <= line_addr + LADDR_W'(1);
               lines_left <= lines_left - (SIZE_W+1)'(1);
               if (issue_last) state <= DRAIN;
            end
            DRAIN: begin
               if (!(|pv)) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pv <= '0;
         pl <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            pc[i]  <= '0;
            plv[i] <= '0;
         end
      end else begin
         pv[0]  <= rd_fire;
         pl[0]  <= rd_fire && issue_last;
         pc[0]  <= cur_ch;
         plv[0] <= issue_last ? tail_lv : '1;
         for (int i = 1; i < RD_LAT; i++) begin
            pv[i]  <= pv[i-1];
            pl[i]  <= pl[i-1];
            pc[i]  <= pc[i-1];
            plv[i] <= plv[i-1];
         end
      end
   end

   always_comb begin
      ch_valid = '0;
      ch_last  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_valid[i] = pv[RD_LAT-1] && (pc[RD_LAT-1] == CH_W'(i));
         ch_last[i]  = ch_valid[i] && pl[RD_LAT-1];
      end
   end

   // data is gated so nothing leaks out while no beat is in flight
   assign ch_last_valid = pv[RD_LAT-1] ? plv[RD_LAT-1] : '0;
   assign ch_data       = pv[RD_LAT-1] ? sram_rdata : '0;
   assign ch_err        = err_q;
   assign sram_rd_en    = rd_fire;
   assign sram_addr     = rd_fire ? line_addr : '0;
   assign busy          = (state != IDLE);

endmodule
